// File: rtl/div_resp_tx.sv
// div_resp_tx: serialises divider results ({shang, yushu}) into UART bytes.
// Results are buffered in a small FIFO; a four-state FSM sends one frame at a time,
// MSB first: shang[15:8], shang[7:0], yushu[15:8], yushu[7:0].
// Optional build macro DIV_RESP_CHK_EN appends a fifth byte holding the XOR of
// the four payload bytes.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | no frame in progress; pops the FIFO head when one is queued
// SEND  | a byte is ready but the transmitter is busy; waits for tx_done
// GUARD | byte just issued; tx_done ignored while the guard timer runs down
// WAIT  | waits for the transmitter to finish before the next byte or IDLE
//
// Issuing a byte from IDLE or WAIT happens on the same edge that sees tx_done
// high, so SEND is only visited when the transmitter is still busy. This gives
// the two-cycle result-to-tx_start latency with a registered tx_start.

module div_resp_tx #(
    parameter int DEPTH = 4,
    parameter int GUARD = 2
) (
    input  logic                       sys_clk,
    input  logic                       sys_rst_n,
    input  logic                       res_valid,
    input  logic [15:0]                shang,
    input  logic [15:0]                yushu,
    input  logic                       tx_done,
    output logic [7:0]                 tx_data,
    output logic                       tx_start,
    output logic                       busy,
    output logic                       ovf,
    output logic [$clog2(DEPTH):0]     fifo_cnt
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int GW = (GUARD > 1) ? $clog2(GUARD + 1) : 1;

`ifdef DIV_RESP_CHK_EN
    localparam logic [2:0] LAST_IDX = 3'd4;
`else
    localparam logic [2:0] LAST_IDX = 3'd3;
`endif

    localparam logic [GW-1:0] GUARD_LD  = GW'(GUARD);
    localparam logic [GW-1:0] GUARD_ONE = GW'(1);
    localparam logic [CW-1:0] CNT_FULL  = CW'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SEND  = 2'd1,
        S_GUARD = 2'd2,
        S_WAIT  = 2'd3
    } state_t;

    state_t          state, state_nxt;
    logic [31:0]     mem [DEPTH];
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   cnt;
    logic [31:0]     fifo_head;
    logic [31:0]     frame;
    logic [2:0]      idx, idx_nxt;
    logic [GW-1:0]   guard_cnt, guard_nxt;
    logic            pop, push, full;
    logic            fire;
    logic [7:0]      fire_byte;
    logic            tx_start_q;
    logic [7:0]      tx_data_q;
    logic            ovf_q;

    // Byte of a frame selected by index; index 4 is the optional checksum.
    function automatic logic [7:0] frame_byte(input logic [31:0] f, input logic [2:0] i);
        logic [7:0] b;
        b = 8'h00;
        case (i)
            3'd0: b = f[31:24];
            3'd1: b = f[23:16];
            3'd2: b = f[15:8];
            3'd3: b = f[7:0];
`ifdef DIV_RESP_CHK_EN
            3'd4: b = f[31:24] ^ f[23:16] ^ f[15:8] ^ f[7:0];
`endif
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    assign full      = (cnt == CNT_FULL);
    assign push      = res_valid && (!full || pop);
    assign fifo_head = mem[rd_ptr];

    // FIFO storage; data needs no reset since cnt gates every read.
    always_ff @(posedge sys_clk) begin
        if (push) begin
            mem[wr_ptr] <= {shang, yushu};
        end
    end

    // FIFO pointers, occupancy and sticky overflow flag.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            ovf_q  <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
            if (res_valid && full && !pop) begin
                ovf_q <= 1'b1;
            end
        end
    end

    // FSM state, frame register, byte index and guard down-counter.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state     <= S_IDLE;
            frame     <= 32'h0;
            idx       <= 3'd0;
            guard_cnt <= '0;
        end else begin
            state     <= state_nxt;
            idx       <= idx_nxt;
            guard_cnt <= guard_nxt;
            if (pop) begin
                frame <= fifo_head;
            end
        end
    end

    // Next-state logic, FIFO pop and byte issue decisions.
    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        fire      = 1'b0;
        fire_byte = 8'h00;
        idx_nxt   = idx;
        guard_nxt = guard_cnt;
        case (state)
            S_IDLE: begin
                if (cnt != '0) begin
                    pop     = 1'b1;
                    idx_nxt = 3'd0;
                    if (tx_done) begin
                        fire      = 1'b1;
                        fire_byte = fifo_head[31:24];
                        guard_nxt = GUARD_LD;
                        state_nxt = S_GUARD;
                    end else begin
                        state_nxt = S_SEND;
                    end
                end
            end
            S_SEND: begin
                if (tx_done) begin
                    fire      = 1'b1;
                    fire_byte = frame_byte(frame, idx);
                    guard_nxt = GUARD_LD;
                    state_nxt = S_GUARD;
                end
            end
            S_GUARD: begin
                if (guard_cnt <= GUARD_ONE) begin
                    state_nxt = S_WAIT;
                end else begin
                    guard_nxt = guard_cnt - GUARD_ONE;
                end
            end
            S_WAIT: begin
                if (tx_done) begin
                    if (idx == LAST_IDX) begin
                        state_nxt = S_IDLE;
                    end else begin
                        idx_nxt   = idx + 3'd1;
                        fire      = 1'b1;
                        fire_byte = frame_byte(frame, idx + 3'd1);
                        guard_nxt = GUARD_LD;
                        state_nxt = S_GUARD;
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Registered transmit request; tx_data holds until the next request.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            tx_start_q <= 1'b0;
            tx_data_q  <= 8'h00;
        end else begin
            tx_start_q <= fire;
            if (fire) begin
                tx_data_q <= fire_byte;
            end
        end
    end

    assign tx_start = tx_start_q;
    assign tx_data  = tx_data_q;
    assign ovf      = ovf_q;
    assign fifo_cnt = cnt;
    assign busy     = (state != S_IDLE) || (cnt != '0);

endmodule

// File: tb/tb_div_resp_tx.sv
// Scoreboard bench for div_resp_tx: stimulus pushes expected bytes into a queue,
// a negedge monitor pops and compares on every tx_start. A simple UART model
// drops tx_done for a random number of cycles after each accepted byte.
module tb_div_resp_tx;

    localparam int DEPTH = 4;
    localparam int GUARD = 2;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          sys_clk   = 1'b0;
    logic          sys_rst_n = 1'b0;
    logic          res_valid = 1'b0;
    logic [15:0]   shang     = 16'h0;
    logic [15:0]   yushu     = 16'h0;
    logic          tx_done   = 1'b1;
    logic [7:0]    tx_data;
    logic          tx_start;
    logic          busy;
    logic          ovf;
    logic [CW-1:0] fifo_cnt;

    int        errors  = 0;
    int        checks  = 0;
    logic [7:0] exp_q[$];
    int        n_bytes = 0;
    bit        stall   = 1'b0;
    int        ucnt    = 0;
    bit        st_seen = 1'b0;
    bit        prev_start = 1'b0;
    int        peak    = 0;

    div_resp_tx #(.DEPTH(DEPTH), .GUARD(GUARD)) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .res_valid (res_valid),
        .shang     (shang),
        .yushu     (yushu),
        .tx_done   (tx_done),
        .tx_data   (tx_data),
        .tx_start  (tx_start),
        .busy      (busy),
        .ovf       (ovf),
        .fifo_cnt  (fifo_cnt)
    );

    always #10 sys_clk = ~sys_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference frame: four payload bytes MSB first, plus XOR byte when enabled.
    task automatic push_exp(input logic [15:0] q, input logic [15:0] r);
        exp_q.push_back(q[15:8]);
        exp_q.push_back(q[7:0]);
        exp_q.push_back(r[15:8]);
        exp_q.push_back(r[7:0]);
`ifdef DIV_RESP_CHK_EN
        exp_q.push_back(q[15:8] ^ q[7:0] ^ r[15:8] ^ r[7:0]);
`endif
    endtask

    task automatic send(input logic [15:0] q, input logic [15:0] r, input bit accept);
        @(posedge sys_clk); #1;
        res_valid = 1'b1;
        shang     = q;
        yushu     = r;
        if (accept) push_exp(q, r);
        @(posedge sys_clk); #1;
        res_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((busy || exp_q.size() != 0) && n < 3000) begin
            @(posedge sys_clk); #1;
            n++;
        end
        check({name, "_busy"}, busy, 0);
        check({name, "_pending"}, exp_q.size(), 0);
    endtask

    task automatic wait_bytes(input int target, input string name);
        int n;
        n = 0;
        while (n_bytes < target && n < 2000) begin
            @(negedge sys_clk); #1;
            n++;
        end
        check(name, (n_bytes >= target), 1);
    endtask

    task automatic do_reset();
        @(negedge sys_clk); #1;
        sys_rst_n = 1'b0;
        #1;
        exp_q.delete();
        check("rst_tx_start", tx_start, 0);
        check("rst_tx_data", tx_data, 8'h00);
        check("rst_busy", busy, 0);
        check("rst_ovf", ovf, 0);
        check("rst_fifo_cnt", fifo_cnt, 0);
        repeat (2) @(posedge sys_clk);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
    endtask

    // Scoreboard monitor and protocol checks, sampled on the falling edge.
    initial begin
        logic [7:0] e;
        forever begin
            @(negedge sys_clk);
            st_seen = tx_start;
            if (int'(fifo_cnt) > peak) peak = int'(fifo_cnt);
            if (tx_start) begin
                n_bytes++;
                check("start_while_tx_busy", tx_done, 1);
                check("start_back_to_back", prev_start, 0);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_byte: got %0h expected none", tx_data);
                end else begin
                    e = exp_q.pop_front();
                    check("tx_byte", tx_data, e);
                end
            end
            prev_start = tx_start;
        end
    end

    // UART model: busy for 1..4 cycles after each byte it accepts.
    initial begin
        forever begin
            @(posedge sys_clk); #1;
            if (st_seen) ucnt = $urandom_range(1, 4);
            else if (ucnt > 0) ucnt--;
            tx_done = (ucnt == 0) && !stall;
        end
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int nb;
        int bsz;
        logic [15:0] q;
        logic [15:0] r;

        // Reset state
        repeat (3) @(posedge sys_clk);
        #1;
        check("init_tx_start", tx_start, 0);
        check("init_tx_data", tx_data, 8'h00);
        check("init_busy", busy, 0);
        check("init_ovf", ovf, 0);
        check("init_fifo_cnt", fifo_cnt, 0);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        repeat (3) @(posedge sys_clk);

        // Single result with literal bytes and two-cycle latency
        exp_q.push_back(8'h12);
        exp_q.push_back(8'h34);
        exp_q.push_back(8'h00);
        exp_q.push_back(8'h56);
`ifdef DIV_RESP_CHK_EN
        exp_q.push_back(8'h70);
`endif
        send(16'h1234, 16'h0056, 1'b0);
        check("lat_n1_no_start", tx_start, 0);
        check("lat_n1_cnt", fifo_cnt, 1);
        @(posedge sys_clk); #1;
        check("lat_n2_start", tx_start, 1);
        check("lat_n2_byte", tx_data, 8'h12);
        check("single_busy", busy, 1);
        wait_idle("single");

        // Transmitter stall after the second byte
        nb = n_bytes;
        send(16'hBEEF, 16'hCAFE, 1'b1);
        wait_bytes(nb + 2, "stall_reach_2nd");
        stall = 1'b1;
        nb = n_bytes;
        repeat (100) @(posedge sys_clk);
        @(negedge sys_clk); #2;
        check("stall_no_start", n_bytes, nb);
        stall = 1'b0;
        @(posedge sys_clk);
        @(posedge sys_clk);
        @(negedge sys_clk); #1;
        check("stall_resume_1cyc", n_bytes, nb + 1);
        wait_idle("stall");

        // Burst of five results three cycles apart
        peak = 0;
        for (int k = 1; k <= 5; k++) begin
            send(16'(k * 16'h0101), 16'(k * 16'h0101), 1'b1);
            @(posedge sys_clk);
        end
        wait_idle("burst");
        check("burst_peak", peak, 4);
        check("burst_ovf", ovf, 0);

        // Overflow: frame in progress, transmitter held busy, six results
        nb = n_bytes;
        send(16'h0A0B, 16'h0C0D, 1'b1);
        wait_bytes(nb + 1, "ovf_first_byte");
        stall = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            send(16'(16'h1100 + k), 16'(16'h2200 + k), (k <= 4));
        end
        #1;
        check("ovf_cnt_full", fifo_cnt, 4);
        check("ovf_set", ovf, 1);
        @(negedge sys_clk); #2;
        stall = 1'b0;
        wait_idle("ovf");
        check("ovf_sticky", ovf, 1);
        do_reset();

        // Reset mid-frame with a second result queued
        nb = n_bytes;
        send(16'h5566, 16'h7788, 1'b1);
        send(16'h99AA, 16'hBBCC, 1'b1);
        wait_bytes(nb + 2, "midrst_reach_2nd");
        do_reset();
        send(16'h3141, 16'h5926, 1'b1);
        wait_idle("after_reset");

        // Checksum reference vectors (plain frames in the default build)
        send(16'hA5A5, 16'h0F0F, 1'b1);
        wait_idle("chk_a");
        send(16'h0102, 16'h0304, 1'b1);
        wait_idle("chk_b");

        // Randomized batches, each no larger than the FIFO
        for (int b = 0; b < 20; b++) begin
            bsz = $urandom_range(1, DEPTH);
            for (int i = 0; i < bsz; i++) begin
                q = 16'($urandom);
                r = 16'($urandom);
                send(q, r, 1'b1);
                repeat ($urandom_range(0, 4)) @(posedge sys_clk);
            end
            wait_idle("random");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
